// File: rtl/board_rx_assembler.sv
// board_rx_assembler
//   Deframes a packed 9x9 Go board from a UART byte stream. A frame is the
//   SYNC_BYTE marker followed by PAYLOAD_LEN payload bytes. When CHECKSUM_EN is
//   defined, one more byte follows: the XOR of the payload bytes. Payload byte k,
//   bits [2j+1:2j], carry cell 4k+j, and cell i lands at row i/9, column i%9.
//   Incoming cells build up in a shadow buffer. The shadow is copied to
//   board_out in a single cycle, and only for a frame that validates, so
//   board_out never shows a partial or rejected frame.
//   Optional feature macro: CHECKSUM_EN (adds the CHECK state and checksum byte).
// Ports
//   clk_in     in   system clock
//   reset      in   synchronous, active-high reset
//   rx_data    in   [7:0] byte from the UART receiver
//   rx_valid   in   one-cycle strobe per received byte
//   board_out  out  committed board, board_out[row][col] is a 2-bit cell
//   rx_ready   out  sticky high after the first committed frame
//   new_board  out  one-cycle pulse per commit
//   frame_err  out  one-cycle pulse per discarded frame
//   err_cnt    out  [7:0] saturating count of discarded frames
module board_rx_assembler #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned PAYLOAD_LEN = 21
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [1:0] board_out [0:8][0:8],
  output logic       rx_ready,
  output logic       new_board,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam int unsigned   TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [4:0]    LAST_IDX = 5'(PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
`ifdef CHECKSUM_EN
    S_CHECK   = 2'd2,
`endif
    S_COMMIT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    shadow_q [0:8][0:8];
  logic [1:0]    shadow_d [0:8][0:8];
  logic          bad_q, bad_d;
`ifdef CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif
  logic [1:0]    board_q [0:8][0:8];
  logic          rx_ready_q;
  logic          new_board_q;
  logic          frame_err_q;
  logic [7:0]    err_cnt_q;

  logic          commit;
  logic          discard;
  logic          tmo_hit;

  // The timer counts consecutive idle cycles. An accepted byte takes
  // precedence over an expiring timer.
  assign tmo_hit = !rx_valid && (timer_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    shadow_d = shadow_q;
    bad_d    = bad_q;
`ifdef CHECKSUM_EN
    csum_d   = csum_q;
`endif
    commit   = 1'b0;
    discard  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = S_PAYLOAD;
          idx_d   = '0;
          timer_d = '0;
          bad_d   = 1'b0;
`ifdef CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      S_PAYLOAD: begin
        if (rx_valid) begin
          timer_d = '0;
          // Scan all 81 cells and write the ones owned by this byte index.
          // This keeps every shadow index constant.
          for (int unsigned r = 0; r < 9; r++) begin
            for (int unsigned c = 0; c < 9; c++) begin
              if (idx_q == 5'((r * 9 + c) >> 2)) begin
                shadow_d[r][c] = rx_data[2 * ((r * 9 + c) % 4) +: 2];
                if (rx_data[2 * ((r * 9 + c) % 4) +: 2] == 2'b11) begin
                  bad_d = 1'b1;
                end
              end
            end
          end
`ifdef CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef CHECKSUM_EN
            state_d = S_CHECK;
`else
            if (bad_d) begin
              discard = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_COMMIT;
            end
`endif
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else if (tmo_hit) begin
          discard = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

`ifdef CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) begin
          timer_d = '0;
          // An illegal cell seen earlier is reported here, at the end of the frame.
          if (bad_q || (rx_data != csum_q)) begin
            discard = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_COMMIT;
          end
        end else if (tmo_hit) begin
          discard = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif

      S_COMMIT: begin
        // Any byte that arrives in this cycle is dropped.
        commit  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      shadow_q    <= '{default: '0};
      bad_q       <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q      <= '0;
`endif
      board_q     <= '{default: '0};
      rx_ready_q  <= 1'b0;
      new_board_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      shadow_q    <= shadow_d;
      bad_q       <= bad_d;
`ifdef CHECKSUM_EN
      csum_q      <= csum_d;
`endif
      new_board_q <= commit;
      frame_err_q <= discard;
      if (commit) begin
        board_q    <= shadow_q;
        rx_ready_q <= 1'b1;
      end
      if (discard && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign board_out = board_q;
  assign rx_ready  = rx_ready_q;
  assign new_board = new_board_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
